// File: rtl/pkt_switch_pkg.sv
// ============================================================================
// pkt_switch_pkg : shared constants and types for the packet switch
// Rev 1.0
// ============================================================================
`default_nettype none

package pkt_switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DEST_W    = 2;

  typedef logic [DEST_W-1:0] dest_t;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } ifb_state_t;

endpackage

`default_nettype wire

// File: rtl/ifb_mem.sv
// ============================================================================
// ifb_mem : dual-port RAM, synchronous write, asynchronous (show-ahead) read
// Rev 1.0
// ============================================================================
`default_nettype none

module ifb_mem #(
  parameter  int WIDTH = 35,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/ingress_frame_buffer.sv
// ============================================================================
// ingress_frame_buffer : store-and-forward frame buffer for one ingress port
// Optional dropped-frame counter: INGRESS_DROP_COUNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ingress_frame_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int DEST_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_last,
  input  logic              out_ready,
  output logic [15:0]       drop_count
);

  import pkt_switch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = DEST_W + 1 + DATA_W;

  ifb_state_t        state, state_nxt;
  logic [PW-1:0]     wptr, rptr, fstart, frame_cnt;
  logic [DEST_W-1:0] cur_dest, wr_dest;
  logic [MW-1:0]     rd_word;
  logic              full, accept, wr_en, commit, rewind, egress, rd_last_xfer;

  assign full    = (wptr - rptr) == PW'(DEPTH);
  assign s_ready = (state == DROP) || !full;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rewind    = 1'b0;
    wr_dest   = cur_dest;
    case (state)
      HEAD: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_dest = s_data[DEST_W-1:0];
          if (s_last) commit = 1'b1;
          else        state_nxt = BODY;
        end
      end
      BODY: begin
        if (accept) begin
          wr_en = 1'b1;
          if (s_last) begin
            commit    = 1'b1;
            state_nxt = HEAD;
          end
        end else if (full && frame_cnt == '0) begin
          // Frame alone fills the whole buffer: it can never be committed
          rewind    = 1'b1;
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (accept && s_last) state_nxt = HEAD;
      end
      default: state_nxt = HEAD;
    endcase
  end

  assign out_valid    = frame_cnt != '0;
  assign egress       = out_valid && out_ready;
  assign rd_last_xfer = egress && rd_word[DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HEAD;
      wptr      <= '0;
      rptr      <= '0;
      fstart    <= '0;
      frame_cnt <= '0;
      cur_dest  <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en)       wptr <= wptr + PW'(1);
      else if (rewind) wptr <= fstart;
      if (commit) fstart <= wptr + PW'(1);
      if (state == HEAD && accept) cur_dest <= s_data[DEST_W-1:0];
      if (egress) rptr <= rptr + PW'(1);
      case ({commit, rd_last_xfer})
        2'b10:   frame_cnt <= frame_cnt + PW'(1);
        2'b01:   frame_cnt <= frame_cnt - PW'(1);
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  ifb_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr[AW-1:0]),
    .wr_data ({wr_dest, s_last, s_data}),
    .rd_addr (rptr[AW-1:0]),
    .rd_data (rd_word)
  );

  // Memory is never reset, so outputs are masked until a frame is complete
  assign out_data = out_valid ? rd_word[DATA_W-1:0] : '0;
  assign out_last = out_valid && rd_word[DATA_W];
  assign out_dest = out_valid ? rd_word[MW-1 -: DEST_W] : '0;

`ifdef INGRESS_DROP_COUNT_EN
  logic [15:0] drop_counter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_counter <= '0;
    end else if (state == DROP && accept && s_last && drop_counter != 16'hFFFF) begin
      drop_counter <= drop_counter + 16'd1;
    end
  end

  assign drop_count = drop_counter;
`else
  assign drop_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ingress_frame_buffer.sv
// ============================================================================
// tb_ingress_frame_buffer : directed self-checking bench, DEPTH = 4 instance
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ingress_frame_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int DEST_W = 2;
`ifdef INGRESS_DROP_COUNT_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [DEST_W-1:0] out_dest;
  logic              out_last;
  logic              out_ready;
  logic [15:0]       drop_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ingress_frame_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DEST_W (DEST_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_dest   (out_dest),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word, wait (bounded) for s_ready, transfer it on the next edge
  task automatic send(input string tag, input logic [31:0] d, input logic last);
    int n;
    n       = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, s_ready, 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Check the show-ahead word, then take it
  task automatic recv(input string tag, input logic [31:0] d, input logic [1:0] dest,
                      input logic last);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"},  out_data,  d);
    check({tag, "_dest"},  out_dest,  dest);
    check({tag, "_last"},  out_last,  last);
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_out_valid", out_valid, 0);
    check("rst_s_ready",   s_ready,   1);
    check("rst_out_last",  out_last,  0);
    check("rst_out_dest",  out_dest,  0);
    check("rst_out_data",  out_data,  0);
    check("rst_drop",      drop_count, 0);

    // 3-word frame to dest 2, egress always ready
    out_ready = 1'b1;
    send("t1_w1", 32'h0000_0102, 1'b0);
    send("t1_w2", 32'h0000_00A1, 1'b0);
    check("t1_no_cut_through", out_valid, 0);
    send("t1_w3", 32'h0000_00A2, 1'b1);
    recv("t1_r1", 32'h0000_0102, 2'd2, 1'b0);
    recv("t1_r2", 32'h0000_00A1, 2'd2, 1'b0);
    recv("t1_r3", 32'h0000_00A2, 2'd2, 1'b1);
    check("t1_empty", out_valid, 0);

    // Two 1-word frames held back, then drained
    out_ready = 1'b0;
    send("t2_a", 32'h0000_0001, 1'b1);
    send("t2_b", 32'h0000_0003, 1'b1);
    check("t2_frame_cnt", dut.frame_cnt, 2);
    check("t2_hold_dest", out_dest, 1);
    tick();
    check("t2_stable_dest", out_dest, 1);
    check("t2_stable_data", out_data, 1);
    recv("t2_r1", 32'h0000_0001, 2'd1, 1'b1);
    recv("t2_r2", 32'h0000_0003, 2'd3, 1'b1);
    check("t2_empty", out_valid, 0);

    // Oversized 6-word frame: rewind after word 4, words 5-6 discarded
    for (int i = 0; i < 6; i++) begin
      send("t3_w", 32'h10 + i, i == 5);
      check("t3_no_valid", out_valid, 0);
      if (i == 3) check("t3_full_ready", s_ready, 0);
    end
    check("t3_wptr_rewound", dut.wptr, 5);
    check("t3_drop_count", drop_count, EXP_DROP);
    send("t3_n1", 32'h0000_0023, 1'b0);
    send("t3_n2", 32'h0000_0024, 1'b1);
    recv("t3_r1", 32'h0000_0023, 2'd3, 1'b0);
    recv("t3_r2", 32'h0000_0024, 2'd3, 1'b1);

    // Stored 3-word frame plus second frame: backpressure, not drop
    out_ready = 1'b0;
    send("t4_a1", 32'h0000_0031, 1'b0);
    send("t4_a2", 32'h0000_0032, 1'b0);
    send("t4_a3", 32'h0000_0033, 1'b1);
    send("t4_b1", 32'h0000_0042, 1'b0);
    check("t4_backpressure", s_ready, 0);
    tick();
    check("t4_still_held", s_ready, 0);
    recv("t4_ra1", 32'h0000_0031, 2'd1, 1'b0);
    recv("t4_ra2", 32'h0000_0032, 2'd1, 1'b0);
    recv("t4_ra3", 32'h0000_0033, 2'd1, 1'b1);
    check("t4_b_incomplete", out_valid, 0);
    send("t4_b2", 32'h0000_0043, 1'b0);
    send("t4_b3", 32'h0000_0044, 1'b1);
    recv("t4_rb1", 32'h0000_0042, 2'd2, 1'b0);
    recv("t4_rb2", 32'h0000_0043, 2'd2, 1'b0);
    recv("t4_rb3", 32'h0000_0044, 2'd2, 1'b1);
    check("t4_drop_count", drop_count, EXP_DROP);

    // Commit of B on the same edge as the last read of A
    out_ready = 1'b0;
    send("t5_a", 32'h0000_0051, 1'b1);
    check("t5_cnt_before", dut.frame_cnt, 1);
    s_data    = 32'h0000_0062;
    s_last    = 1'b1;
    s_valid   = 1'b1;
    out_ready = 1'b1;
    check("t5_ready", s_ready, 1);
    check("t5_a_last", out_last, 1);
    tick();
    s_valid   = 1'b0;
    s_last    = 1'b0;
    out_ready = 1'b0;
    check("t5_cnt_after", dut.frame_cnt, 1);
    check("t5_valid_after", out_valid, 1);
    recv("t5_rb", 32'h0000_0062, 2'd2, 1'b1);

    // Reset in the middle of a frame with a committed frame waiting
    out_ready = 1'b0;
    send("t6_c", 32'h0000_007E, 1'b1);
    send("t6_w1", 32'h0000_0071, 1'b0);
    send("t6_w2", 32'h0000_0072, 1'b0);
    check("t6_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data",  out_data,  0);
    check("t6_rst_dest",  out_dest,  0);
    check("t6_rst_last",  out_last,  0);
    check("t6_rst_ready", s_ready,   1);
    check("t6_rst_drop",  drop_count, 0);
    tick();
    reset = 1'b0;
    tick();
    send("t6_n1", 32'h0000_0083, 1'b0);
    send("t6_n2", 32'h0000_0084, 1'b1);
    recv("t6_r1", 32'h0000_0083, 2'd3, 1'b0);
    recv("t6_r2", 32'h0000_0084, 2'd3, 1'b1);
    check("t6_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
